// File: rtl/ir_command_transmitter_pkg.sv
// IR protocol definitions shared by the command transmitter and the rover-side receiver,
// so both ends decode the frame with the same state encoding and timing units.
package ir_command_transmitter_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        START_BURST = 3'd1,
        BIT_GAP     = 3'd2,
        BIT_BURST   = 3'd3,
        FRAME_GAP   = 3'd4,
        DONE        = 3'd5
    } ir_state_e;

    localparam int IR_CLOCK_FREQ       = 27_000_000;
    localparam int IR_CARRIER_HZ       = 40_000;
    localparam int IR_UNIT_US          = 600;
    localparam int IR_START_UNITS      = 4;
    localparam int IR_ONE_UNITS        = 2;
    localparam int IR_ZERO_UNITS       = 1;
    localparam int IR_GAP_UNITS        = 1;
    localparam int IR_INTERFRAME_UNITS = 40;
    localparam int IR_FRAME_REPEATS    = 3;
    localparam int IR_CMD_BITS         = 12;

    function automatic int unitCycles(input int clockFreq, input int unitUs);
        return (clockFreq / 1_000_000) * unitUs;
    endfunction

    function automatic int carrierHalfPeriod(input int clockFreq, input int carrierHz);
        return clockFreq / (2 * carrierHz);
    endfunction

endpackage

// File: rtl/ir_tick_generator.sv
// Carrier divider and unit-tick strobe. phaseRestart_i realigns both so that a burst
// entered on that edge starts with the carrier high and a full unit ahead of it.
module ir_tick_generator #(
    parameter int UNIT_CYCLES = 10,
    parameter int HALF_PERIOD = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic phaseRestart_i,
    output logic unitTick_o,
    output logic carrier_o
);

    localparam int CYC_W  = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int HALF_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(UNIT_CYCLES - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_PERIOD - 1);

    logic [CYC_W-1:0]  cycCnt_q;
    logic [HALF_W-1:0] halfCnt_q;
    logic              carrier_q;

    always_ff @(posedge clock) begin
        if (!reset || phaseRestart_i) begin
            cycCnt_q  <= '0;
            halfCnt_q <= '0;
            carrier_q <= 1'b1;
        end else begin
            cycCnt_q <= (cycCnt_q == CYC_LAST) ? '0 : cycCnt_q + 1'b1;
            if (halfCnt_q == HALF_LAST) begin
                halfCnt_q <= '0;
                carrier_q <= ~carrier_q;
            end else begin
                halfCnt_q <= halfCnt_q + 1'b1;
            end
        end
    end

    assign unitTick_o = (cycCnt_q == CYC_LAST);
    assign carrier_o  = carrier_q;

endmodule

// File: rtl/ir_command_transmitter.sv
// Serializes a 12-bit rover command into repeated pulse-width-coded IR frames on a
// modulated carrier and reports busy/done to the main FSM.
module ir_command_transmitter
    import ir_command_transmitter_pkg::*;
#(
    parameter int CLOCK_FREQ       = IR_CLOCK_FREQ,
    parameter int CARRIER_HZ       = IR_CARRIER_HZ,
    parameter int UNIT_US          = IR_UNIT_US,
    parameter int START_UNITS      = IR_START_UNITS,
    parameter int ONE_UNITS        = IR_ONE_UNITS,
    parameter int ZERO_UNITS       = IR_ZERO_UNITS,
    parameter int GAP_UNITS        = IR_GAP_UNITS,
    parameter int INTERFRAME_UNITS = IR_INTERFRAME_UNITS,
    parameter int FRAME_REPEATS    = IR_FRAME_REPEATS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   send,
    input  logic [IR_CMD_BITS-1:0] command,
    output logic                   ir_out,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             state
);

    localparam int UNIT_CYCLES = unitCycles(CLOCK_FREQ, UNIT_US);
    localparam int HALF_PERIOD = carrierHalfPeriod(CLOCK_FREQ, CARRIER_HZ);
    localparam int REP_W       = (FRAME_REPEATS > 1) ? $clog2(FRAME_REPEATS) : 1;

    localparam logic [REP_W-1:0] REP_LAST  = REP_W'(FRAME_REPEATS - 1);
    localparam logic [3:0]       BIT_LAST  = 4'(IR_CMD_BITS - 1);
    localparam logic [5:0]       START_LEN = 6'(START_UNITS);
    localparam logic [5:0]       ONE_LEN   = 6'(ONE_UNITS);
    localparam logic [5:0]       ZERO_LEN  = 6'(ZERO_UNITS);
    localparam logic [5:0]       GAP_LEN   = 6'(GAP_UNITS);
    localparam logic [5:0]       IFG_LEN   = 6'(INTERFRAME_UNITS);

    ir_state_e              state_q;
    logic [IR_CMD_BITS-1:0] cmd_q;
    logic [IR_CMD_BITS-1:0] shift_q;
    logic [5:0]             unitCnt_q;
    logic [3:0]             bitIdx_q;
    logic [REP_W-1:0]       repCnt_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   burst_q;

    logic       unitTick;
    logic       carrier;
    logic [5:0] stateLen;
    logic       stateEnd;
    logic       accept;
    logic       phaseRestart;

    // Length in units of the state being timed; BIT_BURST depends on the bit now in flight.
    always_comb begin
        stateLen = 6'd1;
        case (state_q)
            START_BURST: stateLen = START_LEN;
            BIT_GAP:     stateLen = GAP_LEN;
            BIT_BURST:   stateLen = shift_q[0] ? ONE_LEN : ZERO_LEN;
            FRAME_GAP:   stateLen = IFG_LEN;
            default:     stateLen = 6'd1;
        endcase
    end

    assign stateEnd     = unitTick && (unitCnt_q == stateLen - 6'd1);
    assign accept       = (state_q == IDLE) && send;
    assign phaseRestart = accept
                       || (stateEnd && (state_q == BIT_GAP || state_q == FRAME_GAP));

    ir_tick_generator #(
        .UNIT_CYCLES (UNIT_CYCLES),
        .HALF_PERIOD (HALF_PERIOD)
    ) u_tick (
        .clock          (clock),
        .reset          (reset),
        .phaseRestart_i (phaseRestart),
        .unitTick_o     (unitTick),
        .carrier_o      (carrier)
    );

    // Frame sequencer: the shift register is reloaded from the latched word at each frame start.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            shift_q   <= '0;
            unitCnt_q <= '0;
            bitIdx_q  <= '0;
            repCnt_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            burst_q   <= 1'b0;
        end else begin
            if (busy_q && unitTick) begin
                unitCnt_q <= stateEnd ? 6'd0 : unitCnt_q + 6'd1;
            end
            case (state_q)
                IDLE: begin
                    if (send) begin
                        cmd_q     <= command;
                        shift_q   <= command;
                        unitCnt_q <= '0;
                        bitIdx_q  <= '0;
                        repCnt_q  <= '0;
                        busy_q    <= 1'b1;
                        burst_q   <= 1'b1;
                        state_q   <= START_BURST;
                    end
                end
                START_BURST: begin
                    if (stateEnd) begin
                        burst_q <= 1'b0;
                        state_q <= BIT_GAP;
                    end
                end
                BIT_GAP: begin
                    if (stateEnd) begin
                        burst_q <= 1'b1;
                        state_q <= BIT_BURST;
                    end
                end
                BIT_BURST: begin
                    if (stateEnd) begin
                        burst_q <= 1'b0;
                        shift_q <= shift_q >> 1;
                        if (bitIdx_q == BIT_LAST) begin
                            bitIdx_q <= '0;
                            state_q  <= FRAME_GAP;
                        end else begin
                            bitIdx_q <= bitIdx_q + 4'd1;
                            state_q  <= BIT_GAP;
                        end
                    end
                end
                FRAME_GAP: begin
                    if (stateEnd) begin
                        shift_q <= cmd_q;
                        if (repCnt_q == REP_LAST) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            repCnt_q <= repCnt_q + REP_W'(1);
                            burst_q  <= 1'b1;
                            state_q  <= START_BURST;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    burst_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ir_out = carrier & burst_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign state  = state_q;

endmodule
